reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Register-hazard scheduler between the Decode and Data-Fetch stages of the in-order core.
- Tracks in-flight writes per architectural register with small pending-write counters.
- Decides each cycle whether the head micro-op may issue (RAW on sources, counter overflow on destinations).
- Releases registers on write-back and is bulk-cleared on pipeline flush (branch redirect).

Parameters:
- NREGS, 32, number of tracked registers; register index width is clog2(NREGS).
- CNT_W, 2, pending-write counter width per register; max in flight per register is 2^CNT_W-1.
- STALL_W, 32, width of the stall-cycle statistics counter.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- iss_valid  in  1  Decode presents a micro-op
- iss_src1_en, iss_src2_en, iss_src3_en  in  1 each  source operand reads a register
- iss_src1, iss_src2, iss_src3  in  clog2(NREGS) each  source register indices
- iss_dst1_en, iss_dst2_en  in  1 each  op writes a destination (dst2 used for RDX of the RDX:RAX pair and for the stack pointer)
- iss_dst1, iss_dst2  in  clog2(NREGS) each  destination indices
- iss_ready  out  1  combinational: op may issue this cycle
- iss_fire  out  1  iss_valid & iss_ready
- wb_valid  in  1  write-back retiring an op
- wb_dst1_en, wb_dst2_en  in  1 each  retiring op had a destination
- wb_dst1, wb_dst2  in  clog2(NREGS) each  retiring destination indices
- flush  in  1  synchronous clear of all pending state
- busy_vec  out  NREGS  registered; bit i = counter[i] != 0
- stall_cycles  out  STALL_W  count of cycles with iss_valid & !iss_ready
- wb_underflow  out  1  sticky error flag

Behaviour:
- Reset (async): all counters 0, busy_vec 0, stall_cycles 0, wb_underflow 0. iss_ready is combinational and is 1 while reset is held if no source is enabled.
- iss_ready = !flush & no enabled source has counter != 0 & no enabled destination has counter == max.
- iss_ready uses registered counters only. There is no bypass: a write-back in cycle N does not unblock a source until cycle N+1.
- iss_fire increments the counter of each enabled destination by 1.
  - If dst1 == dst2 with both enabled, that register is incremented once.
- wb_valid decrements the counter of each enabled wb destination by 1.
  - If wb_dst1 == wb_dst2 with both enabled, that register is decremented once.
- Same register hit by an issue increment and a wb decrement in one cycle: net change 0.
- Write-back to a register whose counter is 0: the counter stays 0 and wb_underflow is set; it clears only on reset.
- Overflow cannot occur, because iss_ready blocks it. The counter saturates at max as a safety measure.
- flush: on the next edge all counters go to 0. Any iss_fire or wb_valid in the same cycle is ignored; iss_ready is forced 0 during flush. After a flush the pipeline suppresses write-backs from killed ops.
- busy_vec updates on the same edge as the counters, i.e. 1 cycle after iss_fire.
- stall_cycles increments on each edge where iss_valid & !iss_ready & !flush. It wraps modulo 2^STALL_W.
- Sources and destinations on the same op: the RAW check uses pre-issue state only, so an op reading and writing the same free register issues.

Test Plan:
- Reset, then issue op dst1=0 (RAX) -> busy_vec=0x1 next cycle. Next op src1=0 -> iss_ready=0. wb dst1=0 -> that op issues the following cycle; stall_cycles=2.
- Three issues with dst1=4, no wb (CNT_W=2) -> counter 3. A fourth op with dst1=4 -> iss_ready=0. One wb -> it issues.
- Same-cycle iss_fire dst1=3 and wb dst1=3 with counter 1 -> counter stays 1, busy_vec[3]=1.
- RDX:RAX op with dst1=0, dst2=2 -> busy_vec=0x5. Op with dst1=dst2=5 -> counter[5]=1, and one wb clears it.
- Counters on regs 1,7,15 set, then flush with iss_valid=1 -> iss_fire=0 that cycle, busy_vec=0 next cycle, wb_underflow stays 0.
- wb to idle reg 9 -> wb_underflow=1 and counter stays 0. Assert reset mid-operation -> all outputs clear asynchronously.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard between Decode and Data-Fetch: per-register
// pending-write counters gate issue on RAW hazards and counter saturation.
module reg_scoreboard #(
  parameter int NREGS   = 32,
  parameter int CNT_W   = 2,
  parameter int STALL_W = 32,
  localparam int IDX_W  = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iss_valid,
  input  logic               iss_src1_en,
  input  logic               iss_src2_en,
  input  logic               iss_src3_en,
  input  logic [IDX_W-1:0]   iss_src1,
  input  logic [IDX_W-1:0]   iss_src2,
  input  logic [IDX_W-1:0]   iss_src3,
  input  logic               iss_dst1_en,
  input  logic               iss_dst2_en,
  input  logic [IDX_W-1:0]   iss_dst1,
  input  logic [IDX_W-1:0]   iss_dst2,
  output logic               iss_ready,
  output logic               iss_fire,
  input  logic               wb_valid,
  input  logic               wb_dst1_en,
  input  logic               wb_dst2_en,
  input  logic [IDX_W-1:0]   wb_dst1,
  input  logic [IDX_W-1:0]   wb_dst2,
  input  logic               flush,
  output logic [NREGS-1:0]   busy_vec,
  output logic [STALL_W-1:0] stall_cycles,
  output logic               wb_underflow
);

  localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  logic [NREGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NREGS-1:0]            busy_q, busy_d;
  logic [STALL_W-1:0]          stall_q, stall_d;
  logic                        underflow_q, underflow_d;

  logic                        src_hazard_s;
  logic                        dst_full_s;
  logic                        ready_s;
  logic                        fire_s;
  logic [NREGS-1:0]            inc_s;
  logic [NREGS-1:0]            dec_s;

  // Issue gating looks only at registered counters, so write-backs never bypass.
  always_comb begin
    src_hazard_s = (iss_src1_en & (cnt_q[iss_src1] != CNT_ZERO)) |
                   (iss_src2_en & (cnt_q[iss_src2] != CNT_ZERO)) |
                   (iss_src3_en & (cnt_q[iss_src3] != CNT_ZERO));
    dst_full_s   = (iss_dst1_en & (cnt_q[iss_dst1] == CNT_MAX)) |
                   (iss_dst2_en & (cnt_q[iss_dst2] == CNT_MAX));
    ready_s      = ~flush & ~src_hazard_s & ~dst_full_s;
    fire_s       = iss_valid & ready_s;
  end

  // One-hot per-register hit masks; a duplicated index collapses to one hit.
  always_comb begin
    inc_s = {NREGS{1'b0}};
    dec_s = {NREGS{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      inc_s[i] = fire_s &
                 ((iss_dst1_en & (iss_dst1 == IDX_W'(i))) |
                  (iss_dst2_en & (iss_dst2 == IDX_W'(i))));
      dec_s[i] = wb_valid &
                 ((wb_dst1_en & (wb_dst1 == IDX_W'(i))) |
                  (wb_dst2_en & (wb_dst2 == IDX_W'(i))));
    end
  end

  // Counter update: flush wins, a simultaneous inc and dec cancel out.
  always_comb begin
    cnt_d       = cnt_q;
    busy_d      = {NREGS{1'b0}};
    underflow_d = underflow_q;
    for (int i = 0; i < NREGS; i++) begin
      if (flush) begin
        cnt_d[i] = CNT_ZERO;
      end else begin
        case ({inc_s[i], dec_s[i]})
          2'b10: begin
            if (cnt_q[i] == CNT_MAX) begin
              cnt_d[i] = CNT_MAX;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
          2'b01: begin
            if (cnt_q[i] == CNT_ZERO) begin
              cnt_d[i]    = CNT_ZERO;
              underflow_d = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
          end
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
      busy_d[i] = (cnt_d[i] != CNT_ZERO);
    end
  end

  // Stall statistics; wraps naturally at the counter width.
  always_comb begin
    if (iss_valid & ~ready_s & ~flush) begin
      stall_d = stall_q + STALL_ONE;
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= {NREGS{CNT_ZERO}};
      busy_q      <= {NREGS{1'b0}};
      stall_q     <= {STALL_W{1'b0}};
      underflow_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      stall_q     <= stall_d;
      underflow_q <= underflow_d;
    end
  end

  assign iss_ready    = ready_s;
  assign iss_fire     = fire_s;
  assign busy_vec     = busy_q;
  assign stall_cycles = stall_q;
  assign wb_underflow = underflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: per-cycle comparison against a
// counter-array model plus directed hand-computed checkpoints.
module tb_reg_scoreboard;

  localparam int NREGS   = 32;
  localparam int CNT_W   = 2;
  localparam int STALL_W = 32;
  localparam int IDX_W   = 5;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               iss_valid = 1'b0;
  logic               iss_src1_en = 1'b0, iss_src2_en = 1'b0, iss_src3_en = 1'b0;
  logic [IDX_W-1:0]   iss_src1 = '0, iss_src2 = '0, iss_src3 = '0;
  logic               iss_dst1_en = 1'b0, iss_dst2_en = 1'b0;
  logic [IDX_W-1:0]   iss_dst1 = '0, iss_dst2 = '0;
  logic               iss_ready, iss_fire;
  logic               wb_valid = 1'b0;
  logic               wb_dst1_en = 1'b0, wb_dst2_en = 1'b0;
  logic [IDX_W-1:0]   wb_dst1 = '0, wb_dst2 = '0;
  logic               flush = 1'b0;
  logic [NREGS-1:0]   busy_vec;
  logic [STALL_W-1:0] stall_cycles;
  logic               wb_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  int          cnt_m [NREGS];
  logic [31:0] stall_m = 32'd0;
  logic        uf_m = 1'b0;

  reg_scoreboard #(.NREGS(NREGS), .CNT_W(CNT_W), .STALL_W(STALL_W)) dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid),
    .iss_src1_en(iss_src1_en), .iss_src2_en(iss_src2_en), .iss_src3_en(iss_src3_en),
    .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_src3(iss_src3),
    .iss_dst1_en(iss_dst1_en), .iss_dst2_en(iss_dst2_en),
    .iss_dst1(iss_dst1), .iss_dst2(iss_dst2),
    .iss_ready(iss_ready), .iss_fire(iss_fire),
    .wb_valid(wb_valid), .wb_dst1_en(wb_dst1_en), .wb_dst2_en(wb_dst2_en),
    .wb_dst1(wb_dst1), .wb_dst2(wb_dst2),
    .flush(flush), .busy_vec(busy_vec), .stall_cycles(stall_cycles),
    .wb_underflow(wb_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    bit r;
    r = !flush;
    if (iss_src1_en && cnt_m[iss_src1] != 0) r = 1'b0;
    if (iss_src2_en && cnt_m[iss_src2] != 0) r = 1'b0;
    if (iss_src3_en && cnt_m[iss_src3] != 0) r = 1'b0;
    if (iss_dst1_en && cnt_m[iss_dst1] == CMAX) r = 1'b0;
    if (iss_dst2_en && cnt_m[iss_dst2] == CMAX) r = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = 32'd0;
    for (int i = 0; i < NREGS; i++) b[i] = (cnt_m[i] != 0);
    return b;
  endfunction

  // Reference model: sets of registers touched, then net +1/-1 per register.
  always @(posedge clk or posedge reset) begin
    bit rdy;
    bit inc_m [NREGS];
    bit dec_m [NREGS];
    if (reset) begin
      for (int i = 0; i < NREGS; i++) cnt_m[i] = 0;
      stall_m = 32'd0;
      uf_m    = 1'b0;
    end else begin
      rdy = model_ready();
      if (flush) begin
        for (int i = 0; i < NREGS; i++) cnt_m[i] = 0;
      end else begin
        for (int i = 0; i < NREGS; i++) begin
          inc_m[i] = 1'b0;
          dec_m[i] = 1'b0;
        end
        if (iss_valid && rdy) begin
          if (iss_dst1_en) inc_m[iss_dst1] = 1'b1;
          if (iss_dst2_en) inc_m[iss_dst2] = 1'b1;
        end
        if (wb_valid) begin
          if (wb_dst1_en) dec_m[wb_dst1] = 1'b1;
          if (wb_dst2_en) dec_m[wb_dst2] = 1'b1;
        end
        for (int i = 0; i < NREGS; i++) begin
          if (inc_m[i] && !dec_m[i] && cnt_m[i] < CMAX) cnt_m[i]++;
          if (dec_m[i] && !inc_m[i]) begin
            if (cnt_m[i] == 0) uf_m = 1'b1;
            else cnt_m[i]--;
          end
        end
      end
      if (iss_valid && !rdy && !flush) stall_m = stall_m + 32'd1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("iss_ready",    32'(iss_ready),    32'(model_ready()));
    check("iss_fire",     32'(iss_fire),     32'(iss_valid & model_ready()));
    check("busy_vec",     busy_vec,          model_busy());
    check("stall_cycles", stall_cycles,      stall_m);
    check("wb_underflow", 32'(wb_underflow), 32'(uf_m));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    iss_valid = 1'b0;
    iss_src1_en = 1'b0; iss_src2_en = 1'b0; iss_src3_en = 1'b0;
    iss_dst1_en = 1'b0; iss_dst2_en = 1'b0;
    wb_valid = 1'b0; wb_dst1_en = 1'b0; wb_dst2_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic issue_dst(input logic [IDX_W-1:0] d);
    iss_valid = 1'b1; iss_dst1_en = 1'b1; iss_dst1 = d;
  endtask

  task automatic wb_one(input logic [IDX_W-1:0] d);
    wb_valid = 1'b1; wb_dst1_en = 1'b1; wb_dst1 = d;
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(iss_ready), 32'd1);
    check("rst_busy",  busy_vec, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    // RAW stall on RAX, released one cycle after write-back
    issue_dst(5'd0);
    @(negedge clk); check("t1_first_ready", 32'(iss_ready), 32'd1);
    tick(); clr();
    iss_valid = 1'b1; iss_src1_en = 1'b1; iss_src1 = 5'd0;
    @(negedge clk); check("t1_busy", busy_vec, 32'h1);
    check("t1_raw_block", 32'(iss_ready), 32'd0);
    tick(); wb_one(5'd0);
    @(negedge clk); check("t1_no_bypass", 32'(iss_ready), 32'd0);
    tick(); wb_valid = 1'b0; wb_dst1_en = 1'b0;
    @(negedge clk); check("t1_released", 32'(iss_ready), 32'd1);
    check("t1_stall", stall_cycles, 32'd2);
    tick(); clr();

    // Counter saturation on reg 4
    issue_dst(5'd4);
    repeat (3) tick();
    @(negedge clk); check("t2_full_block", 32'(iss_ready), 32'd0);
    check("t2_busy", busy_vec, 32'h10);
    tick(); wb_one(5'd4);
    tick(); wb_valid = 1'b0; wb_dst1_en = 1'b0;
    @(negedge clk); check("t2_unblock", 32'(iss_ready), 32'd1);
    check("t2_stall", stall_cycles, 32'd4);
    tick(); clr(); wb_one(5'd4);
    repeat (3) tick(); clr();
    @(negedge clk); check("t2_drained", busy_vec, 32'h0);

    // Same-cycle issue and write-back on reg 3
    issue_dst(5'd3); tick();
    wb_one(5'd3); tick(); clr();
    @(negedge clk); check("t3_busy_held", busy_vec, 32'h8);
    wb_one(5'd3); tick(); clr();
    @(negedge clk); check("t3_cleared", busy_vec, 32'h0);

    // Paired destinations, including duplicated index
    issue_dst(5'd0); iss_dst2_en = 1'b1; iss_dst2 = 5'd2; tick(); clr();
    @(negedge clk); check("t4_pair_busy", busy_vec, 32'h5);
    wb_one(5'd0); wb_dst2_en = 1'b1; wb_dst2 = 5'd2; tick(); clr();
    issue_dst(5'd5); iss_dst2_en = 1'b1; iss_dst2 = 5'd5; tick(); clr();
    @(negedge clk); check("t4_dup_busy", busy_vec, 32'h20);
    wb_one(5'd5); tick(); clr();
    @(negedge clk); check("t4_dup_clear", busy_vec, 32'h0);
    check("t4_no_uf", 32'(wb_underflow), 32'd0);

    // Flush with a valid op presented
    issue_dst(5'd1); tick();
    issue_dst(5'd7); tick();
    issue_dst(5'd15); tick(); clr();
    @(negedge clk); check("t5_busy", busy_vec, 32'h8082);
    flush = 1'b1; issue_dst(5'd2);
    @(negedge clk); check("t5_fire", 32'(iss_fire), 32'd0);
    check("t5_ready", 32'(iss_ready), 32'd0);
    tick(); clr();
    @(negedge clk); check("t5_flushed", busy_vec, 32'h0);
    check("t5_no_uf", 32'(wb_underflow), 32'd0);
    check("t5_stall", stall_cycles, 32'd4);

    // Underflow, then asynchronous reset mid-operation
    wb_one(5'd9); tick(); clr();
    @(negedge clk); check("t6_uf", 32'(wb_underflow), 32'd1);
    check("t6_busy", busy_vec, 32'h0);
    issue_dst(5'd6); tick(); clr();
    @(negedge clk); check("t6_busy6", busy_vec, 32'h40);
    #2 reset = 1'b1;
    #1;
    check("t6_async_busy",  busy_vec, 32'h0);
    check("t6_async_stall", stall_cycles, 32'd0);
    check("t6_async_uf",    32'(wb_underflow), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
